mskrnd_lfsr_source: RTL and testbench
=====================================

# mskrnd_lfsr_source

Fresh-randomness producer for the masked datapath: the supplying end of the `rnd` interface of the DOM AND gadgets. It holds a 64-bit Fibonacci LFSR, accepts a seed over a valid/ready handshake, and runs a warm-up phase. It then delivers `RW = N_GADGETS*d*(d-1)/2` fresh bits per transfer to a bank of gadgets. Output bits are registered, and no bit is ever delivered twice.

## Interface
- `d`, default `DEFAULTSHARES` (2): number of shares of the fed gadgets.
- `N_GADGETS`, default 16: number of DOM AND gadgets fed per transfer.
- `WARMUP`, default 128: number of discarded RW-bit advances after each seed load (0 allowed).
- `RW`, localparam = `N_GADGETS*d*(d-1)/2`. Elaboration fails unless 1 <= RW <= 64.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `seed_in` input 64: seed value, sampled on seed handshake.
- `seed_valid` input 1: seed offered.
- `seed_ready` output 1: seed can be accepted this cycle.
- `rnd_out` output RW: fresh random bits, gadget i takes bits `[i*n_rnd +: n_rnd]`.
- `rnd_valid` output 1: `rnd_out` holds unused fresh bits.
- `rnd_ready` input 1: consumer takes `rnd_out` this cycle.
- `seeded` output 1: a seed has been loaded since reset.

## Operation
- LFSR step (one bit): `b = s[63]^s[62]^s[60]^s[59]`, then `s <= {s[62:0], b}`.
- One "advance" is RW unrolled steps in one cycle. After an advance, `s[RW-1:0]` contains only newly generated bits, with bit 0 the newest.
- Seed load: `s <= (seed_in == 0) ? 64'h1 : seed_in`. A zero seed is never loaded.
- State machine: UNSEEDED, WARMUP, RUN.
  - UNSEEDED: `seed_ready=1`, `rnd_valid=0`. On seed handshake, load the seed and set the warm-up counter to WARMUP. Go to WARMUP, or to RUN if WARMUP==0.
  - WARMUP: `seed_ready=0`, `rnd_valid=0`. Advance every cycle and decrement the counter. When the counter reaches 0, go to RUN. The counter width is `$clog2(WARMUP+1)`, and the counter never wraps.
  - RUN: `rnd_valid=1`, `seed_ready=1`.
    - On `rnd_valid & rnd_ready`: advance once. The next cycle presents fresh bits.
    - With `rnd_ready=0`: state and `rnd_out` hold.
    - On seed handshake: load the seed and enter WARMUP (or stay in RUN if WARMUP==0). This takes priority over an advance in the same cycle. A coincident rnd transfer still counts as completed, since the consumer used the current `rnd_out`.
- `rnd_out = s[RW-1:0]` gated to 0 whenever `rnd_valid=0`. Both `s` and `rnd_valid` are registers, so there is no combinational path from inputs to `rnd_out`, `rnd_valid`, or `seed_ready`.
- `seeded` is set on the first seed load and cleared only by reset.

## Timing
- Reset (async assert, released synchronously to `clk`) sets:
  - state = UNSEEDED, `s` = 0, counter = 0;
  - `rnd_valid=0`, `rnd_out=0`, `seed_ready=1`, `seeded=0`.
- Reset mid-WARMUP or mid-RUN returns to UNSEEDED immediately, with `rnd_valid` and `rnd_out` at 0 combinationally with reset assertion.
- Seed accepted at edge T:
  - WARMUP>0: `rnd_valid=1` from cycle T+WARMUP onward, and the first `rnd_out` is the state after WARMUP advances.
  - WARMUP==0: `rnd_valid=1` from cycle T+1, and `rnd_out` = low bits of the loaded seed.
- Throughput: one RW-bit transfer per cycle while `rnd_ready=1`. This matches the gadget's latency-0 randomness input.
- `seed_valid` while `seed_ready=0` (in WARMUP) is ignored. The source must hold it until accepted.

## Test plan
- Basic stream, d=2, N_GADGETS=16 (RW=16), WARMUP=0: seed 64'h1, then `rnd_ready=1` continuously. Required: `rnd_valid=1` one cycle after the seed handshake, and `rnd_out` sequence 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h001B.
- Zero seed, same configuration: seed 64'h0. Required: output sequence identical to the 64'h1 case, and `seeded=1`.
- Warm-up, WARMUP=4: seed 64'h1 accepted at cycle T. Required:
  - `rnd_valid=0` and `rnd_out=0` for cycles T+1..T+3;
  - `rnd_valid=1` at T+4 with `rnd_out`=16'h001B;
  - `seed_valid` pulsed at T+2 is not accepted.
- Backpressure, WARMUP=0: hold `rnd_ready=0` for 5 cycles in RUN. Required: `rnd_out` stable for all 5 cycles, then the sequence resumes with no skipped or repeated value.
- Reseed with a coincident transfer: in RUN, assert `seed_valid=1` (seed 64'h1) and `rnd_ready=1` in the same cycle. Required: the next valid `rnd_out` is 16'h0001 (WARMUP=0), not the advanced state.
- Async reset mid-RUN: assert `rst_n=0` between clock edges. Required: `rnd_valid=0`, `rnd_out=0`, `seeded=0`, and `seed_ready=1` immediately. After release, no `rnd_valid` appears until a new seed is accepted.

Source files
------------

// File: rtl/mskrnd_lfsr_source.sv
// mskrnd_lfsr_source: 64-bit Fibonacci LFSR that supplies fresh randomness
// to a bank of DOM AND gadgets. It takes a seed over a valid/ready handshake,
// discards WARMUP advances, and then delivers RW new bits per transfer.
module mskrnd_lfsr_source #(
  parameter int unsigned d         = 2,
  parameter int unsigned N_GADGETS = 16,
  parameter int unsigned WARMUP    = 128,
  localparam int unsigned RW       = N_GADGETS * d * (d - 1) / 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [63:0]   seed_in,
  input  logic          seed_valid,
  output logic          seed_ready,
  output logic [RW-1:0] rnd_out,
  output logic          rnd_valid,
  input  logic          rnd_ready,
  output logic          seeded
);

  if (RW < 1 || RW > 64) begin : g_rw_check
    $error("mskrnd_lfsr_source: RW must lie in 1..64");
  end

  // A one-bit counter still works for WARMUP == 0, because it is never loaded non-zero.
  localparam int unsigned CW = (WARMUP == 0) ? 1 : $clog2(WARMUP + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WARMUP);

  typedef enum logic [1:0] {
    ST_UNSEEDED,
    ST_WARMUP,
    ST_RUN
  } state_t;

  state_t        state_q, state_d;
  logic [63:0]   s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          seeded_q, seeded_d;
  logic          seed_hs;

  // RW unrolled LFSR steps; afterwards s[RW-1:0] holds only new bits, newest at bit 0.
  function automatic logic [63:0] lfsr_advance(input logic [63:0] s);
    logic [63:0] t;
    t = s;
    for (int unsigned i = 0; i < RW; i++) begin
      t = {t[62:0], t[63] ^ t[62] ^ t[60] ^ t[59]};
    end
    return t;
  endfunction

  assign seed_ready = (state_q != ST_WARMUP);
  assign seed_hs    = seed_valid & seed_ready;
  assign rnd_valid  = valid_q;
  assign rnd_out    = valid_q ? s_q[RW-1:0] : '0;
  assign seeded     = seeded_q;

  // Next-state logic. A seed load wins over an advance in the same cycle.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    cnt_d    = cnt_q;
    seeded_d = seeded_q;
    case (state_q)
      ST_UNSEEDED: begin
        if (seed_hs) begin
          s_d      = (seed_in == 64'd0) ? 64'd1 : seed_in;
          cnt_d    = CNT_INIT;
          seeded_d = 1'b1;
          state_d  = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
        end
      end
      ST_WARMUP: begin
        s_d = lfsr_advance(s_q);
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
        if (cnt_q <= CW'(1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (seed_hs) begin
          s_d      = (seed_in == 64'd0) ? 64'd1 : seed_in;
          cnt_d    = CNT_INIT;
          seeded_d = 1'b1;
          state_d  = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
        end else if (rnd_ready) begin
          s_d = lfsr_advance(s_q);
        end
      end
      default: begin
        state_d = ST_UNSEEDED;
      end
    endcase
    valid_d = (state_d == ST_RUN);
  end

  // State, LFSR, counter and flag registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_UNSEEDED;
      s_q      <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      seeded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      seeded_q <= seeded_d;
    end
  end

endmodule

// File: tb/tb_mskrnd_lfsr_source.sv
// Testbench for mskrnd_lfsr_source: one instance with WARMUP=0 and one with
// WARMUP=4, both RW=16. Each driven cycle pushes the outputs required during
// that cycle. A negedge monitor pops each entry and compares it.
module tb_mskrnd_lfsr_source;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [63:0] seed_in0, seed_in4;
  logic        seed_valid0, seed_valid4;
  logic        seed_ready0, seed_ready4;
  logic [15:0] rnd_out0, rnd_out4;
  logic        rnd_valid0, rnd_valid4;
  logic        rnd_ready0, rnd_ready4;
  logic        seeded0, seeded4;

  mskrnd_lfsr_source #(.d(2), .N_GADGETS(16), .WARMUP(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .seed_in(seed_in0), .seed_valid(seed_valid0),
    .seed_ready(seed_ready0), .rnd_out(rnd_out0), .rnd_valid(rnd_valid0),
    .rnd_ready(rnd_ready0), .seeded(seeded0)
  );

  mskrnd_lfsr_source #(.d(2), .N_GADGETS(16), .WARMUP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .seed_in(seed_in4), .seed_valid(seed_valid4),
    .seed_ready(seed_ready4), .rnd_out(rnd_out4), .rnd_valid(rnd_valid4),
    .rnd_ready(rnd_ready4), .seeded(seeded4)
  );

  typedef struct {
    logic        v;
    logic [15:0] out;
    logic        sr;
    string       tag;
  } exp_t;

  exp_t q0[$];
  exp_t q4[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference: sixteen single-bit Fibonacci LFSR steps.
  function automatic logic [63:0] adv16(input logic [63:0] s);
    for (int i = 0; i < 16; i++) s = {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
    return s;
  endfunction

  task automatic step0(input logic sv, input logic [63:0] sd, input logic rr,
                       input logic ev, input logic [15:0] eo, input string tag);
    @(posedge clk); #1;
    seed_valid0 = sv; seed_in0 = sd; rnd_ready0 = rr;
    q0.push_back('{v: ev, out: eo, sr: 1'b1, tag: tag});
  endtask

  task automatic step4(input logic sv, input logic [63:0] sd, input logic rr,
                       input logic ev, input logic [15:0] eo, input logic esr,
                       input string tag);
    @(posedge clk); #1;
    seed_valid4 = sv; seed_in4 = sd; rnd_ready4 = rr;
    q4.push_back('{v: ev, out: eo, sr: esr, tag: tag});
  endtask

  // Monitor for the WARMUP=0 instance.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check_eq({e.tag, "_valid0"}, 64'(rnd_valid0), 64'(e.v));
      check_eq({e.tag, "_out0"}, 64'(rnd_out0), 64'(e.out));
      check_eq({e.tag, "_sready0"}, 64'(seed_ready0), 64'(e.sr));
    end
  end

  // Monitor for the WARMUP=4 instance.
  always @(negedge clk) begin
    exp_t e;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      check_eq({e.tag, "_valid4"}, 64'(rnd_valid4), 64'(e.v));
      check_eq({e.tag, "_out4"}, 64'(rnd_out4), 64'(e.out));
      check_eq({e.tag, "_sready4"}, 64'(seed_ready4), 64'(e.sr));
    end
  end

  logic [15:0] seq_a [5];
  logic [63:0] s;

  initial begin
    seq_a = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h001B};
    seed_in0 = '0; seed_valid0 = 1'b0; rnd_ready0 = 1'b0;
    seed_in4 = '0; seed_valid4 = 1'b0; rnd_ready4 = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_valid0", 64'(rnd_valid0), 64'd0);
    check_eq("rst_out0", 64'(rnd_out0), 64'd0);
    check_eq("rst_sready0", 64'(seed_ready0), 64'd1);
    check_eq("rst_seeded0", 64'(seeded0), 64'd0);
    check_eq("rst_valid4", 64'(rnd_valid4), 64'd0);
    check_eq("rst_seeded4", 64'(seeded4), 64'd0);
    #2 rst_n = 1'b1;

    // Warm-up instance: seed 1, four hidden advances, and a pulse that is ignored.
    step4(1'b0, 64'd0, 1'b1, 1'b0, 16'h0, 1'b1, "w_idle");
    step4(1'b1, 64'd1, 1'b1, 1'b0, 16'h0, 1'b1, "w_seed");
    step4(1'b0, 64'd0, 1'b1, 1'b0, 16'h0, 1'b0, "w_t0");
    step4(1'b0, 64'd0, 1'b1, 1'b0, 16'h0, 1'b0, "w_t1");
    step4(1'b1, 64'hDEAD_BEEF_0123_4567, 1'b1, 1'b0, 16'h0, 1'b0, "w_t2");
    step4(1'b0, 64'd0, 1'b1, 1'b0, 16'h0, 1'b0, "w_t3");
    step4(1'b0, 64'd0, 1'b1, 1'b1, 16'h001B, 1'b1, "w_t4");
    s = adv16(adv16(adv16(adv16(adv16(64'd1)))));
    for (int i = 0; i < 3; i++) begin
      step4(1'b0, 64'd0, 1'b1, 1'b1, s[15:0], 1'b1, "w_run");
      s = adv16(s);
    end
    // Reseed in RUN: the warm-up runs again and the same first value reappears.
    step4(1'b1, 64'd1, 1'b1, 1'b1, s[15:0], 1'b1, "w_reseed");
    for (int i = 0; i < 4; i++) step4(1'b0, 64'd0, 1'b1, 1'b0, 16'h0, 1'b0, "w_rewarm");
    step4(1'b0, 64'd0, 1'b0, 1'b1, 16'h001B, 1'b1, "w_rerun");
    check_eq("w_seeded4", 64'(seeded4), 64'd1);

    // Basic stream, WARMUP=0, seed 1.
    step0(1'b0, 64'd0, 1'b1, 1'b0, 16'h0, "a_idle");
    step0(1'b1, 64'd1, 1'b1, 1'b0, 16'h0, "a_seed");
    for (int i = 0; i < 5; i++) step0(1'b0, 64'd0, 1'b1, 1'b1, seq_a[i], "a_seq");
    s = adv16(adv16(adv16(adv16(adv16(64'd1)))));
    // Zero seed, loaded together with a transfer: same stream as seed 1.
    step0(1'b1, 64'd0, 1'b1, 1'b1, s[15:0], "z_seed");
    for (int i = 0; i < 5; i++) step0(1'b0, 64'd0, 1'b1, 1'b1, seq_a[i], "z_seq");
    check_eq("z_seeded0", 64'(seeded0), 64'd1);
    s = adv16(adv16(adv16(adv16(adv16(64'd1)))));
    // Backpressure: hold five cycles, then resume with no skipped or repeated value.
    step0(1'b0, 64'd0, 1'b1, 1'b1, s[15:0], "b_pre");
    s = adv16(s);
    for (int i = 0; i < 5; i++) step0(1'b0, 64'd0, 1'b0, 1'b1, s[15:0], "b_hold");
    for (int i = 0; i < 3; i++) begin
      step0(1'b0, 64'd0, 1'b1, 1'b1, s[15:0], "b_resume");
      s = adv16(s);
    end
    // Reseed with a coincident transfer: the seed is loaded, not the advanced state.
    step0(1'b1, 64'd1, 1'b1, 1'b1, s[15:0], "r_seed");
    step0(1'b0, 64'd0, 1'b1, 1'b1, 16'h0001, "r_first");
    step0(1'b0, 64'd0, 1'b1, 1'b1, 16'h0000, "r_second");

    // Async reset asserted between edges while in RUN.
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_eq("ar_valid0", 64'(rnd_valid0), 64'd0);
    check_eq("ar_out0", 64'(rnd_out0), 64'd0);
    check_eq("ar_seeded0", 64'(seeded0), 64'd0);
    check_eq("ar_sready0", 64'(seed_ready0), 64'd1);
    check_eq("ar_valid4", 64'(rnd_valid4), 64'd0);
    check_eq("ar_out4", 64'(rnd_out4), 64'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step0(1'b0, 64'd0, 1'b1, 1'b0, 16'h0, "ar_post");
    @(posedge clk); #6;
    check_eq("ar_post_seeded0", 64'(seeded0), 64'd0);
    check_eq("sb_drain0", 64'(q0.size()), 64'd0);
    check_eq("sb_drain4", 64'(q4.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
